// File: rtl/ram_init_pkg.sv
// Shared defaults and power-up image for the ram_init_v2 memory.
package ram_init_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

    // Power-up value of a word is its own address; callers truncate to their word width.
    function automatic logic [31:0] init_word(input logic [31:0] addr);
        return addr;
    endfunction
endpackage

// File: rtl/ram_init_seq.sv
// Init sweep sequencer for ram_init_v2: walks every address once after reset
// and raises busy for exactly DEPTH cycles. Only used under RAM_INIT_SWEEP_EN.
module ram_init_seq
    import ram_init_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              sweep_we
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] cnt_r;
    logic              busy_r;

    // Sweep counter and busy flag; reset (re)starts the sweep at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            cnt_r <= cnt_r + 1'b1;
            if (cnt_r == LAST_ADDR) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            cnt_r  <= cnt_r;
            busy_r <= 1'b0;
        end
    end

    assign busy       = busy_r;
    assign sweep_addr = cnt_r;
    assign sweep_we   = busy_r & ~rst;
endmodule

// File: rtl/ram_init_v2.sv
// Single-port RAM with read-first sync read and a reset-triggered init sweep
// that restores the power-up image; the sweep is built only with RAM_INIT_SWEEP_EN.
module ram_init_v2
    import ram_init_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    // A cleared valid bit means the word still holds its power-up value.
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] dout_r;
    logic              busy_s;
    logic              sweep_we_s;
    logic [ADDR_W-1:0] sweep_addr_s;

`ifdef RAM_INIT_SWEEP_EN
    ram_init_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy_s),
        .sweep_addr (sweep_addr_s),
        .sweep_we   (sweep_we_s)
    );
`else
    assign busy_s       = 1'b0;
    assign sweep_we_s   = 1'b0;
    assign sweep_addr_s = '0;
`endif

    // Read word: stored data once written, otherwise the power-up image.
    always_comb begin
        if (valid_r[addr]) begin
            rd_data_s = mem_r[addr];
        end else begin
            rd_data_s = DATA_W'(init_word(32'(addr)));
        end
    end

    // Storage update: the sweep restores the image, user writes only when idle.
    always_ff @(posedge clk) begin
        if (sweep_we_s) begin
            valid_r[sweep_addr_s] <= 1'b0;
        end else if (we && !busy_s) begin
            mem_r[addr]   <= din;
            valid_r[addr] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Registered read port; old word is captured on a same-address write.
    always_ff @(posedge clk) begin
        if (rst || busy_s) begin
            dout_r <= '0;
        end else begin
            dout_r <= rd_data_s;
        end
    end

    assign dout = dout_r;
    assign busy = busy_s;
endmodule

// File: tb/tb_ram_init_v2.sv
// Scoreboard bench for ram_init_v2; covers both RAM_INIT_SWEEP_EN builds.
module tb_ram_init_v2;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;
`ifdef RAM_INIT_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              busy;

    ram_init_v2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] dout;
        logic              busy;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] mdl_mem [DEPTH];
    logic              mdl_busy;
    int                mdl_cnt;
    int                total_cnt = 0;
    int                bad_cnt   = 0;
    int                busy_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's expectation, pop and compare after the edge.
    task automatic step(input string tag, input logic r, input logic w,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        rst  = r;
        we   = w;
        addr = a;
        din  = d;
        e.dout = (r || mdl_busy) ? 4'h0 : mdl_mem[a];
        if (!mdl_busy && w) mdl_mem[a] = d;
        if (SWEEP && r) begin
            mdl_busy = 1'b1;
            mdl_cnt  = 0;
        end else if (mdl_busy) begin
            mdl_mem[mdl_cnt] = DATA_W'(mdl_cnt);
            if (mdl_cnt == DEPTH - 1) mdl_busy = 1'b0;
            mdl_cnt++;
        end
        e.busy = mdl_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, "_dout"}, 32'(dout), 32'(e.dout));
        chk({tag, "_busy"}, 32'(busy), 32'(e.busy));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = DATA_W'(i);
        mdl_busy = 1'b0;
        mdl_cnt  = 0;
        rst  = 1'b0;
        we   = 1'b0;
        addr = 4'h0;
        din  = 4'h0;
        #1;
        chk("pwrup_busy", 32'(busy), 32'h0);
        step("pwrup_rd5", 1'b0, 1'b0, 4'h5, 4'h0);
`ifdef RAM_INIT_SWEEP_EN
        step("pre_wr3", 1'b0, 1'b1, 4'h3, 4'hC);
        step("rst_a", 1'b1, 1'b0, 4'h0, 4'h0);
        step("rst_b", 1'b1, 1'b0, 4'h0, 4'h0);
        busy_len = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_len++;
            if (i == 0) step("sweep_gated_wr", 1'b0, 1'b1, 4'h3, 4'hF);
            else if (i < 16) step("sweep", 1'b0, 1'b0, 4'(i), 4'h0);
            else step("post_rd", 1'b0, 1'b0, 4'(i - 16), 4'h0);
        end
        chk("sweep_len", 32'(busy_len), 32'd16);
        step("rd3", 1'b0, 1'b0, 4'h3, 4'h0);
        chk("rd3_pwrup", 32'(dout), 32'h3);
        step("wr7", 1'b0, 1'b1, 4'h7, 4'hA);
        chk("wr7_readfirst", 32'(dout), 32'h7);
        step("rd7", 1'b0, 1'b0, 4'h7, 4'h0);
        chk("rd7_new", 32'(dout), 32'hA);
        step("wr9", 1'b0, 1'b1, 4'h9, 4'h6);
        step("rst_c", 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 8; i++) step("sweep_part", 1'b0, 1'b1, 4'(i), 4'hE);
        step("rst_mid", 1'b1, 1'b0, 4'h0, 4'h0);
        busy_len = 0;
        for (int i = 0; i < 18; i++) begin
            if (busy) busy_len++;
            if (i < 16) step("resweep", 1'b0, 1'b0, 4'h9, 4'h0);
            else if (i == 16) step("rd9", 1'b0, 1'b0, 4'h9, 4'h0);
            else step("rd7b", 1'b0, 1'b0, 4'h7, 4'h0);
        end
        chk("resweep_len", 32'(busy_len), 32'd16);
`else
        step("wr2", 1'b0, 1'b1, 4'h2, 4'h9);
        step("rst_a", 1'b1, 1'b0, 4'h2, 4'h0);
        step("rst_b", 1'b1, 1'b0, 4'h2, 4'h0);
        step("rd2", 1'b0, 1'b0, 4'h2, 4'h0);
        chk("rd2_survives", 32'(dout), 32'h9);
        for (int i = 0; i < 4; i++) step("rd_seq", 1'b0, 1'b0, 4'(i), 4'h0);
        step("wr7", 1'b0, 1'b1, 4'h7, 4'hA);
        chk("wr7_readfirst", 32'(dout), 32'h7);
        step("rd7", 1'b0, 1'b0, 4'h7, 4'h0);
        chk("rd7_new", 32'(dout), 32'hA);
`endif
        for (int i = 0; i < 40; i++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/ram_init_v2.md
RAM_INIT_V2 -- requirements
Module: ram_init_v2

Interface
REQ-001 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 4, word width.
REQ-003 Port `clk`, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 Port `rst`, input, 1 bit: reset; synchronous, active-high.
REQ-005 Port `we`, input, 1 bit: write enable, sampled at the rising edge.
REQ-006 Port `addr`, input, ADDR_W bits: read/write address.
REQ-007 Port `din`, input, DATA_W bits: write data.
REQ-008 Port `dout`, output, DATA_W bits: registered read data.
REQ-009 Port `busy`, output, 1 bit: high while the init sweep runs.

Function
REQ-010 Storage SHALL be DEPTH x DATA_W words.
- Power-up contents: mem[i] = i truncated to DATA_W bits (word 5 = 4'h5).
REQ-011 Read SHALL be synchronous with 1-cycle latency.
- Every non-busy cycle: dout <= mem[addr], regardless of `we`.
REQ-012 Write SHALL occur when we=1 and busy=0.
- Action: mem[addr] <= din at the rising edge.
REQ-013 Simultaneous read/write to the same address SHALL be read-first.
- dout takes the old word; the new word is visible on the next read cycle.
REQ-014 Address wrap: none needed; every ADDR_W-bit value is a valid address.
REQ-015 While busy=1:
- `we`, `addr` and `din` SHALL be ignored.
- dout SHALL be held at 0.
REQ-016 Init sweep, triggered by reset:
- One word per cycle, ascending from address 0 to DEPTH-1.
- Each word is rewritten to its power-up value.
- Duration: exactly DEPTH cycles.
REQ-017 busy SHALL fall in the cycle after address DEPTH-1 is written.
- The first user access is accepted at that edge.
REQ-018 rst asserted mid-sweep SHALL restart the sweep from address 0.

Reset
REQ-019 With rst=1 at a rising edge:
- dout <= 0.
- Sweep counter <= 0.
- busy <= 1 (sweep enabled) or busy <= 0 (sweep disabled).
REQ-020 The sweep SHALL start on the first edge with rst=0.
- Holding rst high keeps busy=1 and dout=0.
REQ-021 Before the first reset, busy SHALL be 0 and memory SHALL hold its power-up contents.

Configuration
REQ-022 Macro RAM_INIT_SWEEP_EN.
- Defined: REQ-015..REQ-018 behaviour is compiled in.
- Undefined: no sweep logic is present.
  - busy is tied to 0.
  - rst only clears dout.
  - Memory contents survive reset.

Structure
REQ-023 Package ram_init_pkg SHALL hold:
- ADDR_W, DATA_W and DEPTH defaults.
- Function init_word(addr) returning the power-up value.
REQ-024 Sub-module ram_init_seq SHALL hold the sweep counter and busy flag.
- Outputs: sweep address, sweep write strobe.
- Instantiated only under RAM_INIT_SWEEP_EN.

Verification
REQ-025 Reset, then 16 cycles of rst=0: busy=1 for exactly 16 cycles, dout=0 throughout, then busy=0.
REQ-026 Reads without writes: addr=0,1,2,3 with we=0 gives dout=0,1,2,3, each one cycle late.
REQ-027 Write then read: we=1, addr=7, din=4'hA, then we=0, addr=7.
- dout on the cycle after the write = 4'h7 (read-first).
- dout on the following cycle = 4'hA.
REQ-028 Sweep gating: write addr=3, din=4'hF while busy=1.
- The write is ignored; a read of addr 3 after the sweep returns 4'h3.
REQ-029 Reset mid-sweep:
- Assert rst at sweep cycle 8: busy stays high for a full 16 cycles after rst falls.
- A word written before the reset reads back its power-up value afterwards.
REQ-030 Macro undefined: write addr=2, din=4'h9, then assert rst.
- busy stays 0.
- A read of addr 2 returns 4'h9.
